sys_output_deskew: RTL and testbench
====================================

// Module: sys_output_deskew
// PURPOSE
//  Downstream of the 2-column systolic array. Takes column outputs (x1, x2) that exit
//  skewed by one cycle (column 2 lags column 1) and realigns them into row vectors.
//  Rows are buffered in a small FIFO and handed to the unified-buffer write port via valid/ready.
// PARAMETERS
//  DATA_W  16  width of one column element
//  DEPTH   4   FIFO depth in rows; power of 2, >=2
// PORTS
//  clk            input   1       clock, rising edge
//  rst            input   1       asynchronous reset, active-low (asserted when 0)
//  clr            input   1       synchronous flush of FIFO, holding reg, counters, error flags
//  cfg_col_en     input   2       enabled columns: 01 = col1 only, 11 = both; others ignore input
//  cfg_valid      input   1       load cfg_col_en into internal col_en; also clears holding reg
//  sys_data_in_x1 input   DATA_W  column-1 result from array
//  sys_valid_in_x1 input  1       column-1 result valid
//  sys_data_in_x2 input   DATA_W  column-2 result from array
//  sys_valid_in_x2 input  1       column-2 result valid
//  out_data_1     output  DATA_W  row element, column 1
//  out_data_2     output  DATA_W  row element, column 2 (0 when col2 disabled)
//  out_valid      output  1       row available (FIFO not empty)
//  out_ready      input   1       consumer accepts row when out_valid & out_ready
//  fifo_full      output  1       FIFO holds DEPTH rows
//  rows_out       output  16      rows handed off since reset/clr, wraps at 2^16
//  skew_err       output  1       sticky: mismatched x1/x2 pairing detected
//  overflow       output  1       sticky: row completed while FIFO full
// BEHAVIOUR
//  Reset (rst=0, async): col_en=00, FIFO empty, hold empty, rows_out=0, all flags 0,
//   out_valid=0, out_data_*=0, fifo_full=0.
//  clr=1: same as reset except col_en is kept; clr has priority over all other events.
//  cfg_valid=1: col_en<=cfg_col_en; the hold reg is emptied; FIFO contents are kept.
//  col_en=01: each sys_valid_in_x1 pushes {x1, 0} at that edge; x2 inputs are ignored.
//  col_en=11, pairing via 1-entry hold reg (hold_v, hold_d):
//   - x2 valid & hold_v: push {hold_d, x2}; hold_v cleared unless x1 valid in the same cycle.
//   - x1 valid: hold_d<=x1, hold_v<=1. Capture and pair in the same cycle is legal
//     (steady stream).
//   - x1 valid & hold_v & !x2 valid: skew_err<=1; the held value is replaced by the new x1.
//   - x2 valid & !hold_v: skew_err<=1; x2 is discarded, no push.
//  col_en=00 or 10: all inputs ignored, no flags.
//  FIFO: out_data_* is driven combinationally from the head entry; out_valid=!empty.
//   - Push and pop in the same cycle while full: both succeed, count unchanged.
//   - Push while full with no pop: row dropped, overflow<=1.
//   - Pop while empty is impossible (out_valid=0).
//   - Pointers are log2(DEPTH)+1 bits; full/empty come from pointer compare.
//  Latency: col1-only, x1 at cycle t -> out_valid at t+1 (FIFO empty).
//   Both columns, x1 at t and x2 at t+1 -> out_valid at t+2.
//  rows_out increments on each out_valid & out_ready.
//  out_data and out_valid are stable while out_valid=1 and out_ready=0.
//  Reset asserted mid-stream: everything clears immediately; partial rows are lost.
// TESTING
//  1 col_en=11; x1=1,2,3 at t0..t2; x2=10,20,30 at t1..t3; out_ready=1
//    -> rows {1,10},{2,20},{3,30} at t2..t4; rows_out=3; no flags.
//  2 col_en=01; x1=7,8; x2 random -> rows {7,0},{8,0}; x2 ignored; skew_err=0.
//  3 col_en=11, DEPTH=4, out_ready=0, stream 5 rows -> fifo_full after 4 rows;
//    5th row dropped; overflow=1. Then out_ready=1 -> exactly the first 4 rows, in order.
//  4 col_en=11; x2 valid with no prior x1 -> skew_err=1, no row.
//    x1 twice without x2, then x2=5 -> single row {second x1,5}.
//  5 FIFO full, out_ready=1, push in same cycle -> no overflow; count stays DEPTH; order kept.
//  6 rst=0 mid-stream with FIFO at 2 rows -> out_valid=0, rows_out=0 immediately.
//    clr with col_en=11 -> col_en kept; the next pairs are produced correctly.

Source files
------------

// File: rtl/sys_output_deskew.sv
`default_nettype none
// ============================================================================
//  Module      : sys_output_deskew
//  Description : Realigns the one-cycle-skewed column outputs of a 2-column
//                systolic array into rows and queues them for the consumer.
//  Revision    : 1.0
// ============================================================================
module sys_output_deskew #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [1:0]        cfg_col_en,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] sys_data_in_x1,
    input  logic              sys_valid_in_x1,
    input  logic [DATA_W-1:0] sys_data_in_x2,
    input  logic              sys_valid_in_x2,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fifo_full,
    output logic [15:0]       rows_out,
    output logic              skew_err,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_COL1_ONLY = 2'b01;
    localparam logic [1:0] c_COL_BOTH  = 2'b11;

    logic [1:0]        r_col_en;
    logic              r_hold_v;
    logic [DATA_W-1:0] r_hold_d;
    logic [DATA_W-1:0] r_mem_1 [DEPTH];
    logic [DATA_W-1:0] r_mem_2 [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [15:0]       r_rows_out;
    logic              r_skew_err;
    logic              r_overflow;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic [DATA_W-1:0] w_push_d1;
    logic [DATA_W-1:0] w_push_d2;
    logic              w_skew;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A cycle that reloads the column configuration ignores the data inputs.
    always_comb begin
        w_push    = 1'b0;
        w_push_d1 = '0;
        w_push_d2 = '0;
        w_skew    = 1'b0;
        if (!cfg_valid) begin
            case (r_col_en)
                c_COL1_ONLY: begin
                    w_push    = sys_valid_in_x1;
                    w_push_d1 = sys_data_in_x1;
                end
                c_COL_BOTH: begin
                    w_push    = sys_valid_in_x2 && r_hold_v;
                    w_push_d1 = r_hold_d;
                    w_push_d2 = sys_data_in_x2;
                    w_skew    = (sys_valid_in_x1 && r_hold_v && !sys_valid_in_x2) ||
                                (sys_valid_in_x2 && !r_hold_v);
                end
                default: ;
            endcase
        end
    end

    assign w_pop   = !w_empty && out_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_en   <= 2'b00;
            r_hold_v   <= 1'b0;
            r_hold_d   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rows_out <= '0;
            r_skew_err <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_hold_v   <= 1'b0;
            r_hold_d   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rows_out <= '0;
            r_skew_err <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (cfg_valid) begin
                r_col_en <= cfg_col_en;
                r_hold_v <= 1'b0;
            end else if (r_col_en == c_COL_BOTH) begin
                if (sys_valid_in_x1) begin
                    r_hold_d <= sys_data_in_x1;
                    r_hold_v <= 1'b1;
                end else if (sys_valid_in_x2 && r_hold_v) begin
                    r_hold_v <= 1'b0;
                end
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_rows_out <= r_rows_out + 16'd1;
            end
            if (w_skew) begin
                r_skew_err <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only visible once pointers cover it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_1[r_wr_ptr[AW-1:0]] <= w_push_d1;
            r_mem_2[r_wr_ptr[AW-1:0]] <= w_push_d2;
        end
    end

    assign out_valid  = !w_empty;
    assign out_data_1 = w_empty ? '0 : r_mem_1[r_rd_ptr[AW-1:0]];
    assign out_data_2 = w_empty ? '0 : r_mem_2[r_rd_ptr[AW-1:0]];
    assign fifo_full  = w_full;
    assign rows_out   = r_rows_out;
    assign skew_err   = r_skew_err;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sys_output_deskew.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_output_deskew
//  Description : Self-checking bench for sys_output_deskew against a queue model.
//  Revision    : 1.0
// ============================================================================
module tb_sys_output_deskew;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic [1:0]        cfg_col_en;
    logic              cfg_valid;
    logic [DATA_W-1:0] sys_data_in_x1;
    logic              sys_valid_in_x1;
    logic [DATA_W-1:0] sys_data_in_x2;
    logic              sys_valid_in_x2;
    logic [DATA_W-1:0] out_data_1;
    logic [DATA_W-1:0] out_data_2;
    logic              out_valid;
    logic              out_ready;
    logic              fifo_full;
    logic [15:0]       rows_out;
    logic              skew_err;
    logic              overflow;

    sys_output_deskew #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .clr             (clr),
        .cfg_col_en      (cfg_col_en),
        .cfg_valid       (cfg_valid),
        .sys_data_in_x1  (sys_data_in_x1),
        .sys_valid_in_x1 (sys_valid_in_x1),
        .sys_data_in_x2  (sys_data_in_x2),
        .sys_valid_in_x2 (sys_valid_in_x2),
        .out_data_1      (out_data_1),
        .out_data_2      (out_data_2),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .fifo_full       (fifo_full),
        .rows_out        (rows_out),
        .skew_err        (skew_err),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a row queue plus the pairing state described by the rules.
    logic [31:0] m_q[$];
    logic [1:0]  m_col_en;
    logic        m_hold_v;
    logic [15:0] m_hold_d;
    logic        m_skew;
    logic        m_ovf;
    logic [15:0] m_rows;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input bit keep_cfg);
        m_q.delete();
        if (!keep_cfg) m_col_en = 2'b00;
        m_hold_v = 1'b0;
        m_hold_d = '0;
        m_skew   = 1'b0;
        m_ovf    = 1'b0;
        m_rows   = '0;
    endtask

    task automatic model_step();
        bit          push;
        logic [31:0] row;
        bit          pop;
        int          occ;
        if (clr) begin
            model_reset(1'b1);
            return;
        end
        push = 0;
        row  = '0;
        occ  = m_q.size();
        pop  = (occ > 0) && out_ready;
        if (cfg_valid) begin
            m_col_en = cfg_col_en;
            m_hold_v = 1'b0;
        end else if (m_col_en == 2'b01) begin
            if (sys_valid_in_x1) begin
                push = 1;
                row  = {sys_data_in_x1, 16'h0000};
            end
        end else if (m_col_en == 2'b11) begin
            if (sys_valid_in_x2) begin
                if (m_hold_v) begin
                    push = 1;
                    row  = {m_hold_d, sys_data_in_x2};
                    m_hold_v = 1'b0;
                end else begin
                    m_skew = 1'b1;
                end
            end else if (sys_valid_in_x1 && m_hold_v) begin
                m_skew = 1'b1;
            end
            if (sys_valid_in_x1) begin
                m_hold_d = sys_data_in_x1;
                m_hold_v = 1'b1;
            end
        end
        if (pop) begin
            void'(m_q.pop_front());
            m_rows = m_rows + 16'd1;
        end
        if (push) begin
            if (occ == DEPTH && !pop) m_ovf = 1'b1;
            else m_q.push_back(row);
        end
    endtask

    task automatic check_all(input string ph);
        check_val({ph, "_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val({ph, "_row"}, {out_data_1, out_data_2}, m_q[0]);
        end
        check_val({ph, "_full"}, 32'(fifo_full), 32'(m_q.size() == DEPTH));
        check_val({ph, "_rows"}, 32'(rows_out), 32'(m_rows));
        check_val({ph, "_skew"}, 32'(skew_err), 32'(m_skew));
        check_val({ph, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic edge_check(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
        clr             = 1'b0;
        cfg_valid       = 1'b0;
        sys_valid_in_x1 = 1'b0;
        sys_valid_in_x2 = 1'b0;
    endtask

    task automatic tick(input string ph, input bit v1, input logic [15:0] d1,
                        input bit v2, input logic [15:0] d2);
        sys_valid_in_x1 = v1;
        sys_data_in_x1  = d1;
        sys_valid_in_x2 = v2;
        sys_data_in_x2  = v2 ? d2 : 16'($urandom);
        edge_check(ph);
    endtask

    task automatic configure(input logic [1:0] ce);
        cfg_valid  = 1'b1;
        cfg_col_en = ce;
        edge_check("cfg");
    endtask

    task automatic do_clr();
        clr = 1'b1;
        edge_check("clr");
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; cfg_valid = 1'b0; cfg_col_en = 2'b00;
        sys_valid_in_x1 = 1'b0; sys_valid_in_x2 = 1'b0;
        sys_data_in_x1 = '0; sys_data_in_x2 = '0; out_ready = 1'b0;
        model_reset(1'b0);
        #1;
        check_all("reset");
        check_val("reset_d1", 32'(out_data_1), 32'h0);
        check_val("reset_d2", 32'(out_data_2), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: aligned stream, both columns
        configure(2'b11);
        out_ready = 1'b1;
        tick("t1", 1, 16'd1, 0, 16'd0);
        tick("t1", 1, 16'd2, 1, 16'd10);
        tick("t1", 1, 16'd3, 1, 16'd20);
        tick("t1", 0, 16'd0, 1, 16'd30);
        tick("t1", 0, 16'd0, 0, 16'd0);
        tick("t1", 0, 16'd0, 0, 16'd0);
        check_val("t1_rows_total", 32'(rows_out), 32'd3);

        // 2: column 1 only, x2 ignored
        configure(2'b01);
        tick("t2", 1, 16'd7, 1, 16'($urandom));
        check_val("t2_first", {out_data_1, out_data_2}, {16'd7, 16'd0});
        tick("t2", 1, 16'd8, 1, 16'($urandom));
        tick("t2", 0, 16'd0, 1, 16'($urandom));
        check_val("t2_noskew", 32'(skew_err), 32'd0);

        // 3: overflow with stalled consumer
        do_clr();
        configure(2'b11);
        out_ready = 1'b0;
        tick("t3", 1, 16'd101, 0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick("t3", i < 4, 16'(102 + i), 1, 16'(201 + i));
        end
        check_val("t3_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick("t3d", 0, 16'd0, 0, 16'd0);
        check_val("t3_rows_total", 32'(rows_out), 32'd4);

        // 4: skew detection
        do_clr();
        tick("t4", 0, 16'd0, 1, 16'd99);
        check_val("t4_skew", 32'(skew_err), 32'd1);
        do_clr();
        out_ready = 1'b0;
        tick("t4", 1, 16'd11, 0, 16'd0);
        tick("t4", 1, 16'd12, 0, 16'd0);
        tick("t4", 0, 16'd0, 1, 16'd5);
        check_val("t4_pair", {out_data_1, out_data_2}, {16'd12, 16'd5});

        // 5: push and pop while full
        do_clr();
        for (int i = 0; i < 5; i++) begin
            tick("t5", 1, 16'(301 + i), i > 0, 16'(400 + i));
        end
        out_ready = 1'b1;
        tick("t5", 0, 16'd0, 1, 16'd405);
        check_val("t5_noovf", 32'(overflow), 32'd0);
        check_val("t5_full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < 5; i++) tick("t5d", 0, 16'd0, 0, 16'd0);

        // 6: asynchronous reset mid-stream, then clr keeping col_en
        out_ready = 1'b0;
        tick("t6", 1, 16'd501, 0, 16'd0);
        tick("t6", 1, 16'd502, 1, 16'd601);
        tick("t6", 1, 16'd503, 1, 16'd602);
        #2;
        rst = 1'b0;
        model_reset(1'b0);
        #1;
        check_all("t6_rst");
        check_val("t6_rst_d1", 32'(out_data_1), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        configure(2'b11);
        tick("t6", 1, 16'd701, 0, 16'd0);
        do_clr();
        out_ready = 1'b1;
        tick("t6c", 1, 16'd801, 0, 16'd0);
        tick("t6c", 1, 16'd802, 1, 16'd901);
        tick("t6c", 0, 16'd0, 1, 16'd902);
        tick("t6c", 0, 16'd0, 0, 16'd0);
        check_val("t6_rows_total", 32'(rows_out), 32'd2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 2) begin
                clr = 1'b1;
            end else if ($urandom_range(0, 99) < 4) begin
                cfg_valid  = 1'b1;
                cfg_col_en = 2'($urandom);
            end
            tick("rnd", $urandom_range(0, 9) < 7, 16'($urandom),
                 $urandom_range(0, 9) < 7, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
